// File: rtl/synchronizer_filtered.sv
`default_nettype none
// ============================================================================
// Module      : synchronizer_filtered
// Description : Multi-bit flop-chain synchronizer with a per-bit persistence
//               filter and registered rise/fall/change strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module synchronizer_filtered #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_STATE = '0,
    parameter int               FILTER_LEN  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             change_o,
    output logic             busy_o
);

    localparam int                 c_cnt_w   = $clog2(FILTER_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    generate
        if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
            $error("synchronizer_filtered: STAGES must be in 2..8");
        end
        if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_bad_filter_len
            $error("synchronizer_filtered: FILTER_LEN must be in 1..255");
        end
    endgenerate

    logic [WIDTH-1:0] r_sync [STAGES];
    logic [WIDTH-1:0] w_last;
    logic [WIDTH-1:0] w_differ;
    logic [WIDTH-1:0] w_update;
    logic [WIDTH-1:0] w_busy;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_change;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < STAGES; n++) begin
                r_sync[n] <= RESET_STATE;
            end
        end else begin
            r_sync[0] <= data_i;
            for (int n = 1; n < STAGES; n++) begin
                r_sync[n] <= r_sync[n-1];
            end
        end
    end

    assign w_last = r_sync[STAGES-1];

    // Each bit counts how long the chain output has disagreed with data_o;
    // any return to agreement restarts the count, discarding short glitches.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [c_cnt_w-1:0] r_cnt;

        assign w_differ[i] = w_last[i] ^ r_data[i];
        assign w_update[i] = w_differ[i] && (r_cnt == c_cnt_max);
        assign w_busy[i]   = |r_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (!w_differ[i] || w_update[i]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end

`ifdef FORMAL
        a_cnt_range: assert property (@(posedge clk) r_cnt < c_cnt_w'(FILTER_LEN));
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data   <= RESET_STATE;
            r_rise   <= '0;
            r_fall   <= '0;
            r_change <= 1'b0;
        end else begin
            r_data   <= (r_data & ~w_update) | (w_last & w_update);
            r_rise   <= w_update & w_last;
            r_fall   <= w_update & ~w_last;
            r_change <= |w_update;
        end
    end

    assign data_o   = r_data;
    assign rise_o   = r_rise;
    assign fall_o   = r_fall;
    assign change_o = r_change;
    assign busy_o   = |w_busy;

`ifdef FORMAL
    a_change_has_pulse: assert property (@(posedge clk) disable iff (reset)
        ((data_o ^ $past(data_o)) & ~(rise_o | fall_o)) == '0);
    a_rise_fall_excl: assert property (@(posedge clk) disable iff (reset)
        (rise_o & fall_o) == '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_synchronizer_filtered.sv
`default_nettype none
// ============================================================================
// Module      : tb_synchronizer_filtered
// Description : Directed self-checking bench; one default-configured instance
//               and one 4-bit, 3-stage, FILTER_LEN=3 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synchronizer_filtered;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:0] a_data_i, a_data_o, a_rise, a_fall;
    logic       a_change, a_busy;
    logic [3:0] b_data_i, b_data_o, b_rise, b_fall;
    logic       b_change, b_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    synchronizer_filtered u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .data_i   (a_data_i),
        .data_o   (a_data_o),
        .rise_o   (a_rise),
        .fall_o   (a_fall),
        .change_o (a_change),
        .busy_o   (a_busy)
    );

    synchronizer_filtered #(
        .WIDTH       (4),
        .STAGES      (3),
        .RESET_STATE (4'hA),
        .FILTER_LEN  (3)
    ) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .data_i   (b_data_i),
        .data_o   (b_data_o),
        .rise_o   (b_rise),
        .fall_o   (b_fall),
        .change_o (b_change),
        .busy_o   (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] hist[$];
    logic [3:0] exp_now, exp_prev, exp_rise, exp_fall;
    int busy_cnt, pulses, changed, high_cnt, rises, falls;

    initial begin
        reset    = 1'b1;
        a_data_i = 1'b0;
        b_data_i = 4'hA;
        repeat (3) tick();

        // Reset state
        check("rst_a_data",   a_data_o, 0);
        check("rst_a_rise",   a_rise,   0);
        check("rst_a_change", a_change, 0);
        check("rst_a_busy",   a_busy,   0);
        check("rst_b_data",   b_data_o, 4'hA);
        check("rst_b_rise",   b_rise,   0);
        check("rst_b_fall",   b_fall,   0);
        check("rst_b_busy",   b_busy,   0);
        reset = 1'b0;

        // Quiet input equal to reset state: no activity
        pulses = 0;
        changed = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pulses  += int'(b_change) + int'(|b_rise) + int'(|b_fall) + int'(b_busy);
            changed += int'(b_data_o != 4'hA);
        end
        check("t2_no_pulses", pulses, 0);
        check("t2_no_change", changed, 0);

        // Default config: two-edge latency
        a_data_i = 1'b1;
        tick();
        check("t1_k0_data", a_data_o, 0);
        tick();
        check("t1_k1_data", a_data_o, 0);
        check("t1_k1_rise", a_rise, 0);
        tick();
        check("t1_k2_data",   a_data_o, 1);
        check("t1_k2_rise",   a_rise,   1);
        check("t1_k2_fall",   a_fall,   0);
        check("t1_k2_change", a_change, 1);
        tick();
        check("t1_k3_data",   a_data_o, 1);
        check("t1_k3_rise",   a_rise,   0);
        check("t1_k3_change", a_change, 0);

        // 4'hA -> 4'h5: STAGES+FILTER_LEN-1 = 5 edges
        b_data_i = 4'h5;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t3_hold_data",   b_data_o, 4'hA);
            check("t3_hold_change", b_change, 0);
        end
        tick();
        check("t3_k5_data",   b_data_o, 4'h5);
        check("t3_k5_rise",   b_rise,   4'h5);
        check("t3_k5_fall",   b_fall,   4'hA);
        check("t3_k5_change", b_change, 1);
        tick();
        check("t3_k6_rise",   b_rise,   0);
        check("t3_k6_fall",   b_fall,   0);
        check("t3_k6_change", b_change, 0);
        check("t3_k6_busy",   b_busy,   0);

        // Back to 4'hA, then a 2-cycle glitch on bit0
        b_data_i = 4'hA;
        repeat (8) tick();
        check("t4_restore", b_data_o, 4'hA);
        b_data_i = 4'hB;
        tick();
        tick();
        b_data_i = 4'hA;
        busy_cnt = 0;
        pulses = 0;
        changed = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            busy_cnt += int'(b_busy);
            pulses   += int'(b_change) + int'(|b_rise) + int'(|b_fall);
            changed  += int'(b_data_o != 4'hA);
        end
        check("t4_glitch_busy",   busy_cnt, 2);
        check("t4_glitch_pulses", pulses,   0);
        check("t4_glitch_data",   changed,  0);

        // 3-cycle pulse on bit0 passes
        b_data_i = 4'hB;
        repeat (3) tick();
        b_data_i = 4'hA;
        rises = 0;
        falls = 0;
        high_cnt = 0;
        changed = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            rises    += int'(b_rise[0]);
            falls    += int'(b_fall[0]);
            high_cnt += int'(b_data_o[0]);
            changed  += int'(b_data_o[3:1] != 3'b101);
        end
        check("t4_pass_rise",   rises,    1);
        check("t4_pass_fall",   falls,    1);
        check("t4_pass_high",   high_cnt, 3);
        check("t4_pass_others", changed,  0);

        // Reset while bit1 has a pending count of 2
        b_data_i = 4'h8;
        repeat (5) tick();
        check("t5_pre_busy", b_busy,   1);
        check("t5_pre_data", b_data_o, 4'hA);
        b_data_i = 4'hA;
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_data", b_data_o, 4'hA);
        check("t5_rst_busy", b_busy,   0);
        check("t5_rst_rise", b_rise,   0);
        check("t5_rst_fall", b_fall,   0);
        tick();
        reset = 1'b0;
        pulses = 0;
        changed = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            pulses  += int'(b_change) + int'(|b_rise) + int'(|b_fall) + int'(b_busy);
            changed += int'(b_data_o != 4'hA);
        end
        check("t5_post_pulses", pulses,  0);
        check("t5_post_data",   changed, 0);

        // Toggle bit2 every 3 cycles; data_o is the input delayed by 5 edges
        hist = {};
        repeat (6) hist.push_back(4'hA);
        rises = 0;
        falls = 0;
        for (int i = 0; i < 51; i++) begin
            if (i % 3 == 0) b_data_i = b_data_i ^ 4'h4;
            tick();
            hist.push_back(b_data_i);
            exp_now  = hist[hist.size()-6];
            exp_prev = hist[hist.size()-7];
            exp_rise = exp_now & ~exp_prev;
            exp_fall = ~exp_now & exp_prev;
            check("t6_data",   b_data_o, exp_now);
            check("t6_rise",   b_rise,   exp_rise);
            check("t6_fall",   b_fall,   exp_fall);
            check("t6_change", b_change, (exp_now != exp_prev) ? 1 : 0);
            rises += int'(b_rise[2]);
            falls += int'(b_fall[2]);
        end
        check("t6_rise_count", rises, 8);
        check("t6_fall_count", falls, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
